uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, runtime-selectable parity and stop-bit count, and a built-in baud-rate tick generator. It is the successor to the fixed 8-bit transmitter. It sits between a parallel producer (CPU/bus bridge) and the serial TX pin. It accepts words through a valid/ready handshake and emits back-to-back frames without producer stalls until the FIFO fills.

## Interface
- `DATA_W`, default 8: data bits per frame. Legal range 5–9.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of 2, at least 2.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be at least 2.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p_data` in DATA_W: word to transmit.
- `data_valid` in 1: producer offers `p_data`.
- `data_ready` out 1: FIFO can accept a word (`!full`).
- `parity_en` in 1: 1 means a parity bit is appended.
- `parity_type` in 1: 0 means even parity, 1 means odd parity.
- `stop2` in 1: 1 means two stop bits, 0 means one.
- `s_data` out 1: serial line. Idles high.
- `busy` out 1: FSM is not in IDLE.
- `tx_done` out 1: one-cycle pulse at the end of each frame.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: a word is written on a rising edge where `data_valid && data_ready`. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE to START: taken when the FIFO is non-empty. On entry to START:
  - the head word is popped into the shift register;
  - `parity_en`, `parity_type` and `stop2` are latched.
  - Changing the config inputs mid-frame has no effect on the current frame.
- Bit timing: every state holds its bit for exactly CLKS_PER_BIT cycles, using a bit-timer counting 0..CLKS_PER_BIT-1.
- START: drives `s_data`=0.
- DATA: sends bits LSB first, DATA_W bits. Exit goes to PARITY if the latched `parity_en` is 1, otherwise to STOP.
- PARITY: the bit sent is `^data` for even parity and `~^data` for odd parity.
- STOP: drives 1 for 1 or 2 bit periods, per the latched `stop2`. On the final cycle of STOP:
  - `tx_done` pulses;
  - if the FIFO is non-empty, the next state is START, with the pop happening on that same edge. No idle bit is inserted.
  - otherwise the next state is IDLE.
- Frame length is (1 + DATA_W + parity_en + 1 + stop2) × CLKS_PER_BIT cycles.
- `fifo_count` updates as +1 on a push, −1 on a pop, and is unchanged on a simultaneous push and pop.

## Timing
- All outputs are registered.
- Reset values:
  - `s_data`=1, `busy`=0, `tx_done`=0, `data_ready`=1, `fifo_count`=0;
  - FSM in IDLE;
  - FIFO pointers cleared.
- Reset asserted mid-frame: on the next edge the frame is aborted, the FIFO is flushed and `s_data` returns to 1. No partial stop bit is emitted.
- Latency from an idle FIFO and idle FSM:
  - word pushed at edge N;
  - `fifo_count`=1 after edge N;
  - at edge N+1 the FSM enters START, `s_data` goes to 0 and `busy` goes to 1, and `fifo_count` returns to 0.
- `tx_done` is high for the single cycle following the last STOP cycle's edge.
- `busy` falls on the same edge that IDLE is entered.
- `data_ready` deasserts on the edge where `fifo_count` reaches FIFO_DEPTH. It reasserts on the edge of the next pop.
- FIFO pointers wrap modulo FIFO_DEPTH. The full and empty flags are distinguished by `fifo_count`.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_W=8, FIFO_DEPTH=8.
- Word 0x55, no parity, 1 stop:
  - `s_data` is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (40 cycles total);
  - `tx_done` pulses once;
  - `busy` is high for exactly 40 cycles.
- Word 0xA2 with parity:
  - even parity: parity bit = 1;
  - odd parity: parity bit = 0;
  - frame is 44 cycles in both cases.
- Word 0xFF with `stop2`=1, followed by a queued 0x00:
  - line is high for 8 cycles after the last data bit;
  - then START of 0x00 with no gap;
  - `tx_done` pulses twice.
- Continuous `data_valid` with data 0..11:
  - `data_ready` deasserts when `fifo_count`=8;
  - 12 frames are emitted back-to-back, in order;
  - no word is lost or duplicated;
  - `fifo_count` ends at 0 and `busy` ends at 0.
- Config toggle mid-frame: toggle `parity_en` from 0 to 1 during the DATA bits of 0x3C. The current frame has no parity bit; the next queued frame includes the parity bit.
- Reset during bit 3 of a frame with 3 words queued:
  - one edge later `s_data`=1, `fifo_count`=0, `busy`=0, `data_ready`=1;
  - no further frames are emitted.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for uart_tx_fifo.
// The producer drives the word and valid; the transmitter returns ready.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output p_data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  p_data,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO.
// Parity and stop-bit config are latched per frame at pop time.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               bus,
  input  logic                        parity_en,
  input  logic                        parity_type,
  input  logic                        stop2,
  output logic                        s_data,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              pen_q, pen_d;
  logic              st2_q, st2_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              sdat_q, sdat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              t_last;
  logic              nempty;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pen_d   = pen_q;
    st2_d   = st2_q;
    pop     = 1'b0;
    done_d  = 1'b0;

    head   = mem_q[rptr_q];
    push   = bus.data_valid && ready_q;
    nempty = cnt_q != '0;
    t_last = tmr_q == T_LAST;
    tmr_d  = (state_q == IDLE || t_last) ? '0 : tmr_q + TW'(1);

    unique case (state_q)
      IDLE: pop = nempty;
      START: begin
        if (t_last) state_d = DATA;
      end
      DATA: begin
        if (t_last) begin
          if (bit_q == B_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (t_last) state_d = STOP;
      end
      STOP: begin
        if (t_last) begin
          if (st2_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d  = 1'b1;
            pop     = nempty;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop always starts a fresh frame, whether from IDLE or end of STOP.
    if (pop) begin
      state_d = START;
      tmr_d   = '0;
      bit_d   = '0;
      shreg_d = head;
      par_d   = (^head) ^ parity_type;
      pen_d   = parity_en;
      st2_d   = stop2;
    end

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = cnt_d != FULL;
    busy_d  = state_d != IDLE;

    case (state_d)
      START:   sdat_d = 1'b0;
      DATA:    sdat_d = shreg_d[0];
      PARITY:  sdat_d = par_d;
      default: sdat_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      st2_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      sdat_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      st2_q   <= st2_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      sdat_q  <= sdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.p_data;
  end

  assign bus.data_ready = ready_q;
  assign s_data         = sdat_q;
  assign busy           = busy_q;
  assign tx_done        = done_q;
  assign fifo_count     = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, DATA_W=8, depth 8).
// Line values are checked every cycle against hand-built frames.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       parity_en;
  logic       parity_type;
  logic       stop2;
  logic       s_data;
  logic       busy;
  logic       tx_done;
  logic [3:0] fifo_count;

  int passes;
  int fails;
  int total;

  uart_tx_fifo_if #(.DATA_W(8)) bus ();

  uart_tx_fifo #(
    .DATA_W      (8),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .parity_en  (parity_en),
    .parity_type(parity_type),
    .stop2      (stop2),
    .s_data     (s_data),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    bus.p_data     = w;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (s_data !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 100), 1);
  endtask

  // Called on the first START cycle; returns on the cycle after the frame.
  task automatic frame_chk(input string tag, input logic [7:0] w,
                           input bit pen, input bit par,
                           input bit st2, input int tog);
    logic [11:0] bits;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
    nb = 9;
    if (pen) begin
      bits[nb] = par;
      nb++;
    end
    nb = nb + 1 + int'(st2);
    for (int c = 0; c < nb * 4; c++) begin
      if (c == tog) parity_en = 1'b1;
      chk({tag, "_line"}, s_data, bits[c/4]);
      chk({tag, "_busy"}, busy, 1);
      if (c > 0) chk({tag, "_nodone"}, tx_done, 0);
      tick();
    end
    chk({tag, "_done"}, tx_done, 1);
  endtask

  function automatic logic seq_bit(input int rel);
    int w;
    int b;
    w = rel / 40;
    b = (rel % 40) / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return 1'((w >> (b - 1)) & 1);
    return 1'b1;
  endfunction

  initial begin
    int   idx;
    int   ndone;
    int   nlow;
    int   nbusy;
    bit   acc;
    bit   saw_full;

    passes = 0;
    fails  = 0;
    total  = 0;
    rst            = 1'b1;
    parity_en      = 1'b0;
    parity_type    = 1'b0;
    stop2          = 1'b0;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;

    repeat (3) tick();
    chk("rst_sdata", s_data, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", bus.data_ready, 1);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    tick();

    // 0x55, no parity, one stop bit; check push-to-start latency
    push_word(8'h55);
    chk("lat_count1", fifo_count, 1);
    chk("lat_idle", busy, 0);
    chk("lat_line", s_data, 1);
    tick();
    chk("lat_count0", fifo_count, 0);
    frame_chk("f55", 8'h55, 0, 0, 0, -1);
    chk("f55_idle", busy, 0);
    tick();
    chk("f55_pulse", tx_done, 0);

    // 0xA2 even parity -> 1, odd parity -> 0
    parity_en   = 1'b1;
    parity_type = 1'b0;
    push_word(8'hA2);
    wait_start("a2e_start");
    frame_chk("a2e", 8'hA2, 1, 1, 0, -1);
    chk("a2e_idle", busy, 0);
    parity_type = 1'b1;
    push_word(8'hA2);
    wait_start("a2o_start");
    frame_chk("a2o", 8'hA2, 1, 0, 0, -1);
    chk("a2o_idle", busy, 0);
    parity_en   = 1'b0;
    parity_type = 1'b0;

    // 0xFF with two stop bits then queued 0x00, no gap between
    stop2 = 1'b1;
    push_word(8'hFF);
    push_word(8'h00);
    wait_start("ff_start");
    frame_chk("ff", 8'hFF, 0, 0, 1, -1);
    frame_chk("z0", 8'h00, 0, 0, 1, -1);
    chk("z0_idle", busy, 0);
    stop2 = 1'b0;
    tick();

    // Continuous valid with 0..11
    idx            = 0;
    ndone          = 0;
    saw_full       = 1'b0;
    bus.p_data     = 8'd0;
    bus.data_valid = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      acc = bus.data_valid && bus.data_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx == 12) bus.data_valid = 1'b0;
        else bus.p_data = 8'(idx);
      end
      if (fifo_count == 4'd8) begin
        saw_full = 1'b1;
        chk("seq_ready_full", bus.data_ready, 0);
      end
      if (tx_done === 1'b1) ndone++;
      if (cyc >= 1) begin
        if (cyc - 1 < 480) chk("seq_line", s_data, seq_bit(cyc - 1));
        else chk("seq_tail", s_data, 1);
      end
    end
    chk("seq_full_seen", 32'(saw_full), 1);
    chk("seq_pushed", idx, 12);
    chk("seq_frames", ndone, 12);
    chk("seq_count", fifo_count, 0);
    chk("seq_busy", busy, 0);
    chk("seq_ready", bus.data_ready, 1);

    // Parity enabled mid-frame only affects the next frame
    push_word(8'h3C);
    push_word(8'h3C);
    wait_start("tog_start");
    frame_chk("tog1", 8'h3C, 0, 0, 0, 14);
    frame_chk("tog2", 8'h3C, 1, 0, 0, -1);
    chk("tog_idle", busy, 0);
    parity_en = 1'b0;
    tick();

    // Reset in bit 3 of a frame with three words queued
    push_word(8'h00);
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    chk("rmid_count", fifo_count, 3);
    repeat (11) tick();
    chk("rmid_line_pre", s_data, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_sdata", s_data, 1);
    chk("rmid_count0", fifo_count, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_ready", bus.data_ready, 1);
    chk("rmid_done", tx_done, 0);
    nlow  = 0;
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (s_data !== 1'b1) nlow++;
      if (busy !== 1'b0) nbusy++;
    end
    chk("rmid_quiet_line", nlow, 0);
    chk("rmid_quiet_busy", nbusy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
